// File: rtl/xbar_cfg_pkg.sv
// Shared types and constants for the crossbar configuration loader.
package xbar_cfg_pkg;

    localparam int CELL_BITS = 20;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        LOAD,
        VERIFY,
        DONE
    } cfg_state_t;

    function automatic int CFG_BYTES(input int total);
        return total / 8;
    endfunction

endpackage

// File: rtl/shift_clk_gen.sv
// Registered divide-by-two shift clock with drive/sample strobes for the loader FSM.
module shift_clk_gen (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic shift_clk_o,
    output logic drive_strobe,
    output logic sample_strobe
);

    logic ph;
    logic primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph          <= 1'b0;
            primed      <= 1'b0;
            shift_clk_o <= 1'b0;
        end else if (!run) begin
            ph          <= 1'b0;
            primed      <= 1'b0;
            shift_clk_o <= 1'b0;
        end else begin
            ph          <= ~ph;
            shift_clk_o <= ph;
            if (ph)
                primed <= 1'b1;
        end
    end

    // The edge that drops shift_clk both launches the next bit and, once a rise
    // has occurred, captures the tail bit of the previous one.
    assign drive_strobe  = run & ~ph;
    assign sample_strobe = run & ~ph & primed;

endmodule

// File: rtl/xbar_cfg_loader.sv
// Byte-fed shadow register shifted into the crossbar config chain, then re-shifted and verified.
module xbar_cfg_loader #(
    parameter int NUM_CELLS  = 4,
    parameter int CELL_BITS  = xbar_cfg_pkg::CELL_BITS,
    parameter int TOTAL_BITS = NUM_CELLS * CELL_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    cfg_data,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          verify_err,
    output logic [$clog2(TOTAL_BITS)-1:0] err_idx,
    output logic                          shift_clk_o,
    output logic                          shift_en_o,
    output logic                          shift_d_o,
    input  logic                          shift_q_i
);
    import xbar_cfg_pkg::*;

    localparam int NB = CFG_BYTES(TOTAL_BITS);
    localparam int BW = $clog2(NB + 1);
    localparam int IW = $clog2(TOTAL_BITS);

    if ((TOTAL_BITS % 8) != 0) begin : g_bad_len
        $error("xbar_cfg_loader: TOTAL_BITS must be a multiple of 8");
    end

    cfg_state_t            state;
    logic [TOTAL_BITS-1:0] shadow;
    logic [BW-1:0]         byte_cnt;
    logic [IW-1:0]         bit_cnt;
    logic                  drive_strobe;
    logic                  sample_strobe;
    logic                  hs;

    assign hs = cfg_valid & cfg_ready;

    shift_clk_gen u_clk_gen (
        .clk          (clk),
        .rst          (rst),
        .run          (busy),
        .shift_clk_o  (shift_clk_o),
        .drive_strobe (drive_strobe),
        .sample_strobe(sample_strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            cfg_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            verify_err <= 1'b0;
            err_idx    <= '0;
            shift_en_o <= 1'b0;
            shift_d_o  <= 1'b0;
        end else begin
            case (state)
                IDLE, FILL, DONE: begin
                    if (state == DONE)
                        done <= ~verify_err;
                    if (hs) begin
                        shadow[{byte_cnt, 3'b000} +: 8] <= cfg_data;
                        done <= 1'b0;
                        if (state == DONE) begin
                            verify_err <= 1'b0;
                            err_idx    <= '0;
                        end
                        if (byte_cnt == BW'(NB - 1)) begin
                            byte_cnt  <= '0;
                            bit_cnt   <= '0;
                            state     <= LOAD;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= FILL;
                        end
                    end
                end
                LOAD, VERIFY: begin
                    if (drive_strobe) begin
                        if (!sample_strobe) begin
                            shift_d_o  <= shadow[0];
                            shift_en_o <= 1'b1;
                        end else begin
                            // Tail bits during LOAD are stale chain contents.
                            if (state == VERIFY && shift_q_i != shadow[bit_cnt] && !verify_err) begin
                                verify_err <= 1'b1;
                                err_idx    <= bit_cnt;
                            end
                            if (bit_cnt == IW'(TOTAL_BITS - 1)) begin
                                bit_cnt <= '0;
                                if (state == LOAD) begin
                                    state     <= VERIFY;
                                    shift_d_o <= shadow[0];
                                end else begin
                                    state      <= DONE;
                                    shift_en_o <= 1'b0;
                                    shift_d_o  <= 1'b0;
                                    busy       <= 1'b0;
                                    cfg_ready  <= 1'b1;
                                end
                            end else begin
                                bit_cnt   <= bit_cnt + 1'b1;
                                shift_d_o <= shadow[bit_cnt + 1'b1];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Directed bench for xbar_cfg_loader with a behavioural 80-bit chain model on the shift port.
module tb_xbar_cfg_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready, busy, done, verify_err;
    logic [6:0] err_idx;
    logic       shift_clk_o, shift_en_o, shift_d_o, shift_q_i;

    xbar_cfg_loader dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .busy       (busy),
        .done       (done),
        .verify_err (verify_err),
        .err_idx    (err_idx),
        .shift_clk_o(shift_clk_o),
        .shift_en_o (shift_en_o),
        .shift_d_o  (shift_d_o),
        .shift_q_i  (shift_q_i)
    );

    always #5 clk = ~clk;

    // Chain model: 80 stages, tail output registers the bit that falls off the end.
    logic [79:0] chain = '0;
    logic        q_reg = 1'b0;
    int          rise_cnt = 0;
    logic        fault_on = 1'b0;

    always @(posedge shift_clk_o or negedge busy) begin
        if (!busy)
            rise_cnt <= 0;
        else if (shift_en_o) begin
            q_reg    <= chain[79];
            chain    <= {chain[78:0], shift_d_o};
            rise_cnt <= rise_cnt + 1;
        end
    end

    // Verify bit j is returned after rise 81+j; stuck-at-1 on returned bits 37 and 50.
    assign shift_q_i = q_reg | (fault_on && (rise_cnt == 118 || rise_cnt == 131));

    int         tests = 0;
    int         fails = 0;
    logic [7:0] img [10];
    int         cyc, done_cyc, n_en, pviol, dviol, rviol;
    bit         timeout;
    logic [9:0] seq;

    function automatic logic [79:0] exp_chain();
        logic [79:0] bits;
        logic [79:0] r;
        for (int k = 0; k < 10; k++) bits[8*k +: 8] = img[k];
        for (int k = 0; k < 80; k++) r[79-k] = bits[k];
        return r;
    endfunction

    task automatic load_image(input int first);
        int guard;
        for (int k = first; k < 10; k++) begin
            cfg_data  = img[k];
            cfg_valid = 1'b1;
            guard = 0;
            while (!cfg_ready && guard < 1000) begin
                @(posedge clk); #1;
                guard++;
            end
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
    endtask

    // Runs from just after the last handshake until one cycle after busy drops.
    task automatic run_to_done();
        int   last_rise, after;
        logic pclk, pd;
        bit   seen;
        cyc = 0; done_cyc = 0; n_en = 0; pviol = 0; dviol = 0; rviol = 0;
        timeout = 0; seq = '0; last_rise = -1; after = 0; seen = 0;
        pclk = shift_clk_o; pd = shift_d_o;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (busy) seen = 1;
            if (busy && cfg_ready) rviol++;
            if (shift_clk_o && !pclk) begin
                if (shift_en_o) begin
                    if (n_en < 10) seq[n_en] = shift_d_o;
                    n_en++;
                end
                if (last_rise >= 0 && cyc - last_rise != 2) pviol++;
                last_rise = cyc;
            end
            if (shift_d_o !== pd && shift_clk_o) dviol++;
            pclk = shift_clk_o; pd = shift_d_o;
            if (done && done_cyc == 0) done_cyc = cyc;
            if (seen && !busy) after++;
            if (after == 2) break;
            if (cyc >= 1000) begin timeout = 1; break; end
        end
        tests++;
        if (timeout) begin
            fails++;
            $display("FAIL run_timeout: busy=%b after %0d cycles, required pass to finish", busy, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({cfg_ready, busy, done, verify_err, shift_clk_o, shift_en_o, shift_d_o} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 1000000",
                     {cfg_ready, busy, done, verify_err, shift_clk_o, shift_en_o, shift_d_o});
        end
        tests++;
        if (err_idx !== 7'd0) begin
            fails++;
            $display("FAIL reset_err_idx: got %0d want 0", err_idx);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) img[k] = 8'(k + 1);
        load_image(0);
        run_to_done();
        tests++;
        if (done_cyc != 322) begin
            fails++;
            $display("FAIL b2b_latency: done at cycle %0d want 322", done_cyc);
        end
        tests++;
        if (verify_err !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_status: done=%b verify_err=%b want 1/0", done, verify_err);
        end
        tests++;
        if (seq !== 10'b10_0000_0001) begin
            fails++;
            $display("FAIL b2b_dseq: got %b want 1000000001 (bit0 first)", seq);
        end
        tests++;
        if (chain !== exp_chain()) begin
            fails++;
            $display("FAIL b2b_chain: got %h want %h", chain, exp_chain());
        end
    endtask

    task automatic test_shift_clk();
        img[0] = 8'hC3; img[1] = 8'h5A; img[2] = 8'hFF; img[3] = 8'h00; img[4] = 8'h81;
        img[5] = 8'h7E; img[6] = 8'h24; img[7] = 8'hE7; img[8] = 8'h99; img[9] = 8'h66;
        load_image(0);
        run_to_done();
        tests++;
        if (pviol != 0) begin
            fails++;
            $display("FAIL sclk_period: %0d rise spacings not 2 cycles, want 0", pviol);
        end
        tests++;
        if (dviol != 0) begin
            fails++;
            $display("FAIL sclk_d_stable: %0d d changes with shift_clk high, want 0", dviol);
        end
        tests++;
        if (n_en != 160) begin
            fails++;
            $display("FAIL sclk_en_rises: got %0d want 160", n_en);
        end
        tests++;
        if (done !== 1'b1 || chain !== exp_chain()) begin
            fails++;
            $display("FAIL sclk_image: done=%b chain=%h want 1/%h", done, chain, exp_chain());
        end
    endtask

    task automatic test_stuck_bit();
        for (int k = 0; k < 10; k++) img[k] = 8'h00;
        fault_on = 1'b1;
        load_image(0);
        run_to_done();
        fault_on = 1'b0;
        tests++;
        if (verify_err !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL stuck_status: verify_err=%b done=%b want 1/0", verify_err, done);
        end
        tests++;
        if (err_idx !== 7'd37) begin
            fails++;
            $display("FAIL stuck_err_idx: got %0d want 37", err_idx);
        end
    endtask

    task automatic test_hold_valid();
        for (int k = 0; k < 10; k++) img[k] = 8'(k + 1);
        load_image(0);
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        run_to_done();
        cfg_valid = 1'b0;
        tests++;
        if (rviol != 0) begin
            fails++;
            $display("FAIL hold_ready: cfg_ready high for %0d busy cycles, want 0", rviol);
        end
        tests++;
        if (done !== 1'b0 || verify_err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_accept: done=%b verify_err=%b busy=%b want 0/0/0", done, verify_err, busy);
        end
        img[0] = 8'hA5;
        load_image(1);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL hold_byte0_taken: busy=%b after 9 more bytes, want 1", busy);
        end
        run_to_done();
        tests++;
        if (done_cyc != 322 || chain !== exp_chain()) begin
            fails++;
            $display("FAIL hold_image: done_cyc=%0d chain=%h want 322/%h", done_cyc, chain, exp_chain());
        end
    endtask

    task automatic test_reset_mid_load();
        for (int k = 0; k < 10; k++) img[k] = 8'(8'hF0 ^ k);
        load_image(0);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({cfg_ready, busy, done, verify_err, shift_clk_o, shift_en_o, shift_d_o} !== 7'b1000000
            || err_idx !== 7'd0) begin
            fails++;
            $display("FAIL midrst_outputs: got %b idx=%0d want 1000000 idx=0",
                     {cfg_ready, busy, done, verify_err, shift_clk_o, shift_en_o, shift_d_o}, err_idx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load_image(0);
        run_to_done();
        tests++;
        if (done_cyc != 322 || verify_err !== 1'b0 || chain !== exp_chain()) begin
            fails++;
            $display("FAIL midrst_reload: done_cyc=%0d verify_err=%b want 322/0", done_cyc, verify_err);
        end
    endtask

    task automatic test_gaps();
        int   c, k, bviol;
        logic acc;
        for (int i = 0; i < 10; i++) img[i] = 8'(8'h3C + 7 * i);
        c = 0; k = 0; bviol = 0;
        while (k < 10 && c < 500) begin
            cfg_valid = ((c / 3) % 2 == 0);
            cfg_data  = img[k];
            acc = cfg_valid && cfg_ready;
            if (busy) bviol++;
            @(posedge clk); #1;
            c++;
            if (acc) k++;
        end
        cfg_valid = 1'b0;
        tests++;
        if (k != 10) begin
            fails++;
            $display("FAIL gaps_handshakes: got %0d want 10", k);
        end
        tests++;
        if (bviol != 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL gaps_load_start: early busy %0d, busy now %b, want 0/1", bviol, busy);
        end
        run_to_done();
        tests++;
        if (done_cyc != 322 || chain !== exp_chain()) begin
            fails++;
            $display("FAIL gaps_image: done_cyc=%0d chain=%h want 322/%h", done_cyc, chain, exp_chain());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shift_clk();
        test_stuck_bit();
        test_hold_valid();
        test_reset_mid_load();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
